// File: rtl/memory_stage.sv
// memory_stage: M pipeline stage with a req/ack data-memory port and the W
// pipeline register plus the W-stage result mux.
//
// Ports
//   clk_i, rst_i            clock (rising edge), asynchronous active-low reset
//   *_m_i                   M-stage register outputs (control, ALU result,
//                           store data, destination register)
//   dmem_*                  data-memory bus: req/we/addr/wdata out, ack/rdata in
//   stall_m_o               freeze PC and F/D/E/M while an access is in flight
//   mem_err_o               sticky misaligned / timed-out access flag
//   *_w_o, result_w_o       W pipeline register and the W result mux
//
// Bus handshake: dmem_req_o is held high from the first BUSY cycle until the
// cycle dmem_ack_i is seen high at a rising edge; addr/we/wdata come from
// capture registers and do not change while dmem_req_o is high. The access
// completes in the cycle where dmem_req_o and dmem_ack_i are both 1, and
// dmem_rdata_i is sampled only in that cycle. An ack while req is low is
// ignored.
//
// The FSM state is kept in r_state (state_t) so checkers can bind to it.
module memory_stage #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              reg_write_m_i,
  input  logic              mem_write_m_i,
  input  logic              mem_to_reg_m_i,
  input  logic [31:0]       alu_out_m_i,
  input  logic [31:0]       write_data_m_i,
  input  logic [4:0]        write_reg_m_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [31:0]       dmem_wdata_o,
  input  logic              dmem_ack_i,
  input  logic [31:0]       dmem_rdata_i,
  output logic              stall_m_o,
  output logic              mem_err_o,
  output logic              reg_write_w_o,
  output logic              mem_to_reg_w_o,
  output logic [31:0]       alu_out_w_o,
  output logic [31:0]       read_data_w_o,
  output logic [4:0]        write_reg_w_o,
  output logic [31:0]       result_w_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int              CNT_W        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT - 1);
  localparam logic [31:0]     TIMEOUT_DATA = 32'hDEAD_BEEF;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;

  // Captured access, held across BUSY and DONE.
  logic              r_we;
  logic [31:0]       r_alu_out;
  logic [31:0]       r_wdata;
  logic [4:0]        r_write_reg;
  logic              r_reg_write;
  logic              r_mem_to_reg;
  logic [31:0]       r_rdata;
  logic              r_err;

  // W pipeline register.
  logic              r_reg_write_w;
  logic              r_mem_to_reg_w;
  logic [31:0]       r_alu_out_w;
  logic [31:0]       r_read_data_w;
  logic [4:0]        r_write_reg_w;

  logic              w_mem_op;
  logic              w_misaligned;
  logic              w_start;
  logic              w_ack;
  logic              w_timeout;

  assign w_mem_op     = mem_write_m_i | mem_to_reg_m_i;
  assign w_misaligned = w_mem_op & (alu_out_m_i[1:0] != 2'b00);
  assign w_start      = (r_state == S_IDLE) & w_mem_op & ~w_misaligned;
  assign w_ack        = (r_state == S_BUSY) & dmem_ack_i;
  // A late ack on the last allowed cycle still wins over the timeout.
  assign w_timeout    = (r_state == S_BUSY) & ~dmem_ack_i & (r_cnt == CNT_LAST);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_BUSY;
      S_BUSY:  if (w_ack || w_timeout) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Stall is gated by reset so the pipeline is released immediately even if
  // the frozen M inputs still describe a memory op.
  assign dmem_req_o   = (r_state == S_BUSY);
  assign dmem_we_o    = (r_state == S_BUSY) & r_we;
  assign dmem_addr_o  = r_alu_out[ADDR_W-1:0];
  assign dmem_wdata_o = r_wdata;
  assign stall_m_o    = rst_i & (w_start | (r_state == S_BUSY));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt          <= '0;
      r_we           <= 1'b0;
      r_alu_out      <= '0;
      r_wdata        <= '0;
      r_write_reg    <= '0;
      r_reg_write    <= 1'b0;
      r_mem_to_reg   <= 1'b0;
      r_rdata        <= '0;
      r_err          <= 1'b0;
      r_reg_write_w  <= 1'b0;
      r_mem_to_reg_w <= 1'b0;
      r_alu_out_w    <= '0;
      r_read_data_w  <= '0;
      r_write_reg_w  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_cnt          <= '0;
            r_we           <= mem_write_m_i;
            r_alu_out      <= alu_out_m_i;
            r_wdata        <= write_data_m_i;
            r_write_reg    <= write_reg_m_i;
            r_reg_write    <= reg_write_m_i;
            r_mem_to_reg   <= mem_to_reg_m_i;
            r_rdata        <= '0;
            r_reg_write_w  <= 1'b0;
            r_mem_to_reg_w <= 1'b0;
            r_alu_out_w    <= '0;
            r_read_data_w  <= '0;
            r_write_reg_w  <= '0;
          end else begin
            // Non-memory op, or a misaligned access that is dropped with
            // its register write suppressed.
            if (w_misaligned) r_err <= 1'b1;
            r_reg_write_w  <= reg_write_m_i & ~w_misaligned;
            r_mem_to_reg_w <= mem_to_reg_m_i;
            r_alu_out_w    <= alu_out_m_i;
            r_read_data_w  <= '0;
            r_write_reg_w  <= write_reg_m_i;
          end
        end
        S_BUSY: begin
          r_reg_write_w  <= 1'b0;
          r_mem_to_reg_w <= 1'b0;
          r_alu_out_w    <= '0;
          r_read_data_w  <= '0;
          r_write_reg_w  <= '0;
          if (w_ack) begin
            r_rdata <= r_we ? 32'h0 : dmem_rdata_i;
          end else if (w_timeout) begin
            r_err       <= 1'b1;
            r_rdata     <= TIMEOUT_DATA;
            r_reg_write <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_reg_write_w  <= r_reg_write;
          r_mem_to_reg_w <= r_mem_to_reg;
          r_alu_out_w    <= r_alu_out;
          r_read_data_w  <= r_rdata;
          r_write_reg_w  <= r_write_reg;
        end
        default: ;
      endcase
    end
  end

  assign mem_err_o      = r_err;
  assign reg_write_w_o  = r_reg_write_w;
  assign mem_to_reg_w_o = r_mem_to_reg_w;
  assign alu_out_w_o    = r_alu_out_w;
  assign read_data_w_o  = r_read_data_w;
  assign write_reg_w_o  = r_write_reg_w;
  assign result_w_o     = r_mem_to_reg_w ? r_read_data_w : r_alu_out_w;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage (TIMEOUT = 4). Inputs change 1 ns after a
// rising edge; outputs are sampled at that same point, well away from edges.
module tb_memory_stage;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        reg_write_m_i = 1'b0;
  logic        mem_write_m_i = 1'b0;
  logic        mem_to_reg_m_i = 1'b0;
  logic [31:0] alu_out_m_i = '0;
  logic [31:0] write_data_m_i = '0;
  logic [4:0]  write_reg_m_i = '0;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ack_i = 1'b0;
  logic [31:0] dmem_rdata_i = '0;
  logic        stall_m_o;
  logic        mem_err_o;
  logic        reg_write_w_o;
  logic        mem_to_reg_w_o;
  logic [31:0] alu_out_w_o;
  logic [31:0] read_data_w_o;
  logic [4:0]  write_reg_w_o;
  logic [31:0] result_w_o;

  int checks = 0;
  int errors = 0;

  memory_stage #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .reg_write_m_i(reg_write_m_i), .mem_write_m_i(mem_write_m_i),
    .mem_to_reg_m_i(mem_to_reg_m_i), .alu_out_m_i(alu_out_m_i),
    .write_data_m_i(write_data_m_i), .write_reg_m_i(write_reg_m_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i),
    .dmem_rdata_i(dmem_rdata_i), .stall_m_o(stall_m_o), .mem_err_o(mem_err_o),
    .reg_write_w_o(reg_write_w_o), .mem_to_reg_w_o(mem_to_reg_w_o),
    .alu_out_w_o(alu_out_w_o), .read_data_w_o(read_data_w_o),
    .write_reg_w_o(write_reg_w_o), .result_w_o(result_w_o)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_m(input logic rw, input logic mw, input logic mr,
                       input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] wr);
    reg_write_m_i  = rw;
    mem_write_m_i  = mw;
    mem_to_reg_m_i = mr;
    alu_out_m_i    = alu;
    write_data_m_i = wd;
    write_reg_m_i  = wr;
    #1;
  endtask

  task automatic apply_reset;
    rst_i = 1'b0;
    dmem_ack_i = 1'b0;
    set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    tick;
  endtask

  // Memory responder: runs until stall drops (or a cycle bound), acking on
  // the ack_on-th request cycle (0 = never). Counts stall/req cycles and
  // request cycles where the bus disagrees with the expected access.
  task automatic run_access(input int ack_on, input logic [31:0] rdata,
                            input logic [31:0] exp_addr, input logic exp_we,
                            input logic [31:0] exp_wdata,
                            output int n_stall, output int n_req,
                            output int n_bad, output bit bounded);
    n_stall = 0; n_req = 0; n_bad = 0; bounded = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (!stall_m_o) begin
        bounded = 1'b0;
        break;
      end
      n_stall++;
      if (dmem_req_o) begin
        n_req++;
        if (dmem_addr_o !== exp_addr || dmem_we_o !== exp_we ||
            (exp_we && dmem_wdata_o !== exp_wdata)) n_bad++;
        if (ack_on != 0 && n_req == ack_on) begin
          dmem_ack_i = 1'b1; dmem_rdata_i = rdata;
        end else begin
          dmem_ack_i = 1'b0; dmem_rdata_i = $urandom;
        end
      end else begin
        dmem_ack_i = 1'b0;
      end
      tick;
    end
    dmem_ack_i = 1'b0;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset;
    rst_i = 1'b0;
    // An aligned load on the M inputs must not raise stall while in reset.
    set_m(1'b1, 1'b0, 1'b1, 32'h0000_0010, 32'h0, 5'd1);
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if (stall_m_o !== 1'b0 || dmem_req_o !== 1'b0 || dmem_we_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_bus: stall=%b req=%b we=%b, required 0 0 0", stall_m_o, dmem_req_o, dmem_we_o);
    end
    checks++;
    if (reg_write_w_o !== 1'b0 || mem_to_reg_w_o !== 1'b0 || alu_out_w_o !== 32'h0 ||
        read_data_w_o !== 32'h0 || write_reg_w_o !== 5'd0 || result_w_o !== 32'h0 || mem_err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_w: rw=%b m2r=%b alu=%h rd=%h wr=%0d res=%h err=%b, required all 0",
               reg_write_w_o, mem_to_reg_w_o, alu_out_w_o, read_data_w_o, write_reg_w_o, result_w_o, mem_err_o);
    end
    set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    tick;
  endtask

  task automatic test_alu;
    set_m(1'b1, 1'b0, 1'b0, 32'h0000_0005, 32'h0, 5'd8);
    checks++;
    if (stall_m_o !== 1'b0 || dmem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL alu_stall: stall=%b req=%b, required 0 0", stall_m_o, dmem_req_o);
    end
    tick;
    checks++;
    if (reg_write_w_o !== 1'b1 || write_reg_w_o !== 5'd8 || result_w_o !== 32'h5) begin
      errors++;
      $display("FAIL alu_w: rw=%b wr=%0d res=%h, required 1 8 00000005", reg_write_w_o, write_reg_w_o, result_w_o);
    end
    set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    tick;
  endtask

  task automatic test_load;
    int ns, nr, nb;
    bit tmo;
    set_m(1'b1, 1'b0, 1'b1, 32'h0000_0010, 32'h0, 5'd3);
    run_access(3, 32'hCAFE_F00D, 32'h0000_0010, 1'b0, 32'h0, ns, nr, nb, tmo);
    checks++;
    if (tmo || ns != 4 || nr != 3 || nb != 0) begin
      errors++;
      $display("FAIL load_bus: stall=%0d req=%0d bad=%0d bound=%b, required 4 3 0 0", ns, nr, nb, tmo);
    end
    // DONE cycle: W still holds the bubble.
    checks++;
    if (reg_write_w_o !== 1'b0 || dmem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL load_done: rw_w=%b req=%b, required 0 0", reg_write_w_o, dmem_req_o);
    end
    tick;
    checks++;
    if (reg_write_w_o !== 1'b1 || result_w_o !== 32'hCAFE_F00D || write_reg_w_o !== 5'd3 || mem_to_reg_w_o !== 1'b1) begin
      errors++;
      $display("FAIL load_w: rw=%b res=%h wr=%0d m2r=%b, required 1 cafef00d 3 1",
               reg_write_w_o, result_w_o, write_reg_w_o, mem_to_reg_w_o);
    end
  endtask

  task automatic test_back_to_back;
    // ALU op issued straight after the load left M.
    set_m(1'b1, 1'b0, 1'b0, 32'h0000_0077, 32'h0, 5'd9);
    checks++;
    if (stall_m_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stall: stall=%b, required 0", stall_m_o);
    end
    tick;
    checks++;
    if (reg_write_w_o !== 1'b1 || result_w_o !== 32'h77 || write_reg_w_o !== 5'd9) begin
      errors++;
      $display("FAIL b2b_w: rw=%b res=%h wr=%0d, required 1 00000077 9", reg_write_w_o, result_w_o, write_reg_w_o);
    end
    set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    tick;
  endtask

  task automatic test_store;
    int ns, nr, nb;
    bit tmo;
    set_m(1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'h1234_5678, 5'd0);
    run_access(1, 32'hFFFF_FFFF, 32'h0000_0020, 1'b1, 32'h1234_5678, ns, nr, nb, tmo);
    checks++;
    if (tmo || ns != 2 || nr != 1 || nb != 0) begin
      errors++;
      $display("FAIL store_bus: stall=%0d req=%0d bad=%0d bound=%b, required 2 1 0 0", ns, nr, nb, tmo);
    end
    tick;
    checks++;
    if (reg_write_w_o !== 1'b0 || read_data_w_o !== 32'h0 || alu_out_w_o !== 32'h20 || mem_err_o !== 1'b0) begin
      errors++;
      $display("FAIL store_w: rw=%b rd=%h alu=%h err=%b, required 0 00000000 00000020 0",
               reg_write_w_o, read_data_w_o, alu_out_w_o, mem_err_o);
    end
    set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    tick;
  endtask

  task automatic test_late_ack;
    int ns, nr, nb;
    bit tmo;
    set_m(1'b1, 1'b0, 1'b1, 32'h0000_0030, 32'h0, 5'd6);
    run_access(4, 32'h0BAD_F00D, 32'h0000_0030, 1'b0, 32'h0, ns, nr, nb, tmo);
    checks++;
    if (tmo || ns != 5 || nr != 4 || nb != 0) begin
      errors++;
      $display("FAIL late_ack_bus: stall=%0d req=%0d bad=%0d bound=%b, required 5 4 0 0", ns, nr, nb, tmo);
    end
    tick;
    checks++;
    if (reg_write_w_o !== 1'b1 || result_w_o !== 32'h0BAD_F00D || mem_err_o !== 1'b0) begin
      errors++;
      $display("FAIL late_ack_w: rw=%b res=%h err=%b, required 1 0badf00d 0", reg_write_w_o, result_w_o, mem_err_o);
    end
    set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    tick;
  endtask

  task automatic test_misaligned;
    set_m(1'b1, 1'b0, 1'b1, 32'h0000_0022, 32'h0, 5'd4);
    checks++;
    if (stall_m_o !== 1'b0 || dmem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL misalign_stall: stall=%b req=%b, required 0 0", stall_m_o, dmem_req_o);
    end
    tick;
    checks++;
    if (mem_err_o !== 1'b1 || reg_write_w_o !== 1'b0 || read_data_w_o !== 32'h0 ||
        dmem_req_o !== 1'b0 || alu_out_w_o !== 32'h22 || write_reg_w_o !== 5'd4) begin
      errors++;
      $display("FAIL misalign_w: err=%b rw=%b rd=%h req=%b alu=%h wr=%0d, required 1 0 00000000 0 00000022 4",
               mem_err_o, reg_write_w_o, read_data_w_o, dmem_req_o, alu_out_w_o, write_reg_w_o);
    end
    set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    tick;
  endtask

  task automatic test_timeout;
    int ns, nr, nb;
    bit tmo;
    apply_reset;
    set_m(1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h0, 5'd5);
    run_access(0, 32'h0, 32'h0000_0040, 1'b0, 32'h0, ns, nr, nb, tmo);
    checks++;
    if (tmo || ns != 5 || nr != 4 || nb != 0 || mem_err_o !== 1'b1) begin
      errors++;
      $display("FAIL timeout_bus: stall=%0d req=%0d bad=%0d bound=%b err=%b, required 5 4 0 0 1",
               ns, nr, nb, tmo, mem_err_o);
    end
    tick;
    checks++;
    if (read_data_w_o !== 32'hDEAD_BEEF || reg_write_w_o !== 1'b0 || result_w_o !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL timeout_w: rd=%h rw=%b res=%h, required deadbeef 0 deadbeef",
               read_data_w_o, reg_write_w_o, result_w_o);
    end
    set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    tick;
  endtask

  task automatic test_reset_mid_busy;
    apply_reset;
    set_m(1'b1, 1'b0, 1'b1, 32'h0000_0050, 32'h0, 5'd7);
    tick;
    checks++;
    if (dmem_req_o !== 1'b1 || stall_m_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_busy_pre: req=%b stall=%b, required 1 1", dmem_req_o, stall_m_o);
    end
    rst_i = 1'b0;
    #1;
    checks++;
    if (dmem_req_o !== 1'b0 || stall_m_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy_drop: req=%b stall=%b, required 0 0", dmem_req_o, stall_m_o);
    end
    set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    dmem_ack_i = 1'b1;
    dmem_rdata_i = 32'h5555_AAAA;
    tick;
    tick;
    checks++;
    if (reg_write_w_o !== 1'b0 || read_data_w_o !== 32'h0 || dmem_req_o !== 1'b0 ||
        stall_m_o !== 1'b0 || mem_err_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy_ack: rw=%b rd=%h req=%b stall=%b err=%b, required 0 00000000 0 0 0",
               reg_write_w_o, read_data_w_o, dmem_req_o, stall_m_o, mem_err_o);
    end
    dmem_ack_i = 1'b0;
    tick;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset;
    test_alu;
    test_load;
    test_back_to_back;
    test_store;
    test_late_ack;
    test_misaligned;
    test_timeout;
    test_reset_mid_busy;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
